sig_enc_ctrl: RTL and testbench

SIG_ENC_CTRL -- requirements
Module: sig_enc_ctrl

---
 rtl/sig_enc_ctrl_pkg.sv | 26 ++
 rtl/sig_enc_ctrl_cyc_timer.sv | 40 ++++
 rtl/sig_enc_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sig_enc_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sig_enc_ctrl_pkg.sv
// Shared definitions for the signal-field encoder controller.
//   state_t          : controller FSM encoding
//   LSR_LEN          : length of the encoder's tail-biting shift register
//   DEF_*            : default frame / gap / timeout parameters
//   tmr_width()      : bit width of the shared cycle timer for a given timeout
package sig_enc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_WAIT = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam int LSR_LEN         = 6;
    localparam int DEF_N_BITS      = 32;
    localparam int DEF_GAP_CYC     = 4;
    localparam int DEF_TIMEOUT_CYC = 400;

    // The timer must reach TIMEOUT_CYC exactly, so it needs room for that value.
    function automatic int tmr_width(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/sig_enc_ctrl_cyc_timer.sv
// cyc_timer: clearable, saturating up-counter with a terminal-count compare.
// Ports:
//   clk     in   clock
//   rst     in   synchronous reset, active high (count -> 0)
//   clr     in   force count to 0 (idle / load phases)
//   restart in   load count with 1 (first cycle of a newly entered state)
//   en      in   increment count, saturating at all-ones
//   lim     in   terminal value for the current state
//   tc      out  count equals lim
module cyc_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         restart,
    input  logic         en,
    input  logic [W-1:0] lim,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Counting starts at 1 so the value equals the number of cycles spent in
    // the current state, including the present one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= W'(1);
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == lim);

endmodule

// File: rtl/sig_enc_ctrl.sv
// sig_enc_ctrl: serialises an N_BITS signal field into the tail-biting
// convolutional encoder, waits for the encoder's completion pulse, then
// enforces an idle gap before the next frame.
// Ports:
//   clk          in   clock
//   rst          in   synchronous reset, active high
//   start        in   frame request, taken only while ready=1
//   sig_word     in   signal field, captured when start is taken
//   abort        in   terminate the frame in LOAD/SEND/WAIT
//   sc_done      in   encoder finished pulse (honoured in WAIT only)
//   sc_di        out  serial bit to encoder, LSB first
//   sc_di_init   out  tail-biting LSR seed = top LSR_LEN bits of the word
//   sc_di_vld    out  sc_di valid
//   ready        out  controller idle
//   busy         out  frame in progress
//   done         out  one-cycle pulse, frame completed
//   err_timeout  out  one-cycle pulse, encoder did not finish in time
module sig_enc_ctrl
    import sig_enc_ctrl_pkg::*;
#(
    parameter int N_BITS      = DEF_N_BITS,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_BITS-1:0]   sig_word,
    input  logic                abort,
    input  logic                sc_done,
    output logic                sc_di,
    output logic [LSR_LEN-1:0]  sc_di_init,
    output logic                sc_di_vld,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic                err_timeout
);

    localparam int TW = tmr_width(TIMEOUT_CYC);

    localparam logic [TW-1:0] SEND_LIM = TW'(N_BITS);
    localparam logic [TW-1:0] WAIT_LIM = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] GAP_LIM  = TW'(GAP_CYC);

    state_t             state, state_d;
    logic [N_BITS-1:0]  word;
    logic               accept;
    logic               done_d, err_d;
    logic               tmr_tc, tmr_clr, tmr_restart, tmr_en;
    logic [TW-1:0]      tmr_lim;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // ---------------------------------------------------------------
    // Next-state logic. abort outranks sc_done, which outranks timeout.
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_LOAD;
                    accept  = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = abort ? S_GAP : S_SEND;
            end
            S_SEND: begin
                if (abort)       state_d = S_GAP;
                else if (tmr_tc) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_GAP;
                end else if (sc_done) begin
                    state_d = S_GAP;
                    done_d  = 1'b1;
                end else if (tmr_tc) begin
                    state_d = S_GAP;
                    err_d   = 1'b1;
                end
            end
            S_GAP: begin
                if (tmr_tc) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Shared timer: terminal value follows the current state; the count
    // restarts on every entry into a timed state.
    // ---------------------------------------------------------------
    always_comb begin
        tmr_lim = '0;
        case (state)
            S_SEND:  tmr_lim = SEND_LIM;
            S_WAIT:  tmr_lim = WAIT_LIM;
            S_GAP:   tmr_lim = GAP_LIM;
            default: tmr_lim = '0;
        endcase
    end

    assign tmr_clr     = (state_d == S_IDLE) || (state_d == S_LOAD);
    assign tmr_restart = (state_d != state) && !tmr_clr;
    assign tmr_en      = (state_d == state);

    cyc_timer #(
        .W (TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .restart (tmr_restart),
        .en      (tmr_en),
        .lim     (tmr_lim),
        .tc      (tmr_tc)
    );

    // ---------------------------------------------------------------
    // Word register doubles as the serialiser: it shifts right once per
    // SEND cycle, so bit 0 is always the next bit to emit. The LSR seed is
    // captured separately so it survives the shifting.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            word       <= '0;
            sc_di_init <= '0;
        end else if (accept) begin
            word       <= sig_word;
            sc_di_init <= sig_word[N_BITS-1 -: LSR_LEN];
        end else if (state_d == S_SEND) begin
            word       <= word >> 1;
        end
    end

    // ---------------------------------------------------------------
    // Registered outputs, driven from the next state so they line up with
    // the state they describe.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_di       <= 1'b0;
            sc_di_vld   <= 1'b0;
            ready       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            sc_di       <= (state_d == S_SEND) && word[0];
            sc_di_vld   <= (state_d == S_SEND);
            ready       <= (state_d == S_IDLE);
            busy        <= (state_d != S_IDLE);
            done        <= done_d;
            err_timeout <= err_d;
        end
    end

endmodule

// File: tb/tb_sig_enc_ctrl.sv
module tb_sig_enc_ctrl;

    localparam int NB = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NB-1:0] sig_word;
    logic          abort;
    logic          sc_done;
    logic          sc_di;
    logic [5:0]    sc_di_init;
    logic          sc_di_vld;
    logic          ready;
    logic          busy;
    logic          done;
    logic          err_timeout;

    sig_enc_ctrl #(
        .N_BITS      (NB),
        .GAP_CYC     (4),
        .TIMEOUT_CYC (400)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sig_word    (sig_word),
        .abort       (abort),
        .sc_done     (sc_done),
        .sc_di       (sc_di),
        .sc_di_init  (sc_di_init),
        .sc_di_vld   (sc_di_vld),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [5:0] v;
    } ev_t;

    localparam logic [5:0] K_DONE = 6'd2;
    localparam logic [5:0] K_TMO  = 6'd1;

    ev_t q_bits[$];
    ev_t q_load[$];
    ev_t q_evt[$];
    ev_t q_rdy[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    logic prev_ready = 1'b1;
    logic prev_busy  = 1'b0;
    ev_t  m_e;

    task automatic cmp_ev(input string nm, input logic [5:0] act, input ev_t e);
        n_cmp++;
        if (act !== e.v || cyc != e.c) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h at cycle %0d, expected 0x%0h at cycle %0d",
                     nm, act, cyc, e.v, e.c);
        end
    endtask

    task automatic unexp(input string nm, input logic [5:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected event 0x%0h at cycle %0d, none expected", nm, act, cyc);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected responses whenever the DUT presents one.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sc_di_vld === 1'b1) begin
                if (q_bits.size() == 0) unexp("sc_di", {5'b0, sc_di});
                else begin m_e = q_bits.pop_front(); cmp_ev("sc_di", {5'b0, sc_di}, m_e); end
            end else begin
                n_cmp++;
                if (sc_di !== 1'b0) begin
                    n_bad++;
                    $display("FAIL sc_di_idle: got %b with sc_di_vld=0, expected 0 (cycle %0d)",
                             sc_di, cyc);
                end
            end
            if (busy === 1'b1 && prev_busy === 1'b0) begin
                if (q_load.size() == 0) unexp("load", sc_di_init);
                else begin m_e = q_load.pop_front(); cmp_ev("load_init", sc_di_init, m_e); end
            end
            if (done === 1'b1 || err_timeout === 1'b1) begin
                if (q_evt.size() == 0) unexp("done_err", {4'b0, done, err_timeout});
                else begin m_e = q_evt.pop_front(); cmp_ev("done_err", {4'b0, done, err_timeout}, m_e); end
            end
            if (ready === 1'b1 && prev_ready === 1'b0) begin
                if (q_rdy.size() == 0) unexp("ready", 6'd1);
                else begin m_e = q_rdy.pop_front(); cmp_ev("ready_rise", 6'd1, m_e); end
            end
        end
        prev_ready <= ready;
        prev_busy  <= busy;
    end

    task automatic run_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame taken at cycle t: LOAD at t+1 with the seed, bit k at t+2+k.
    task automatic push_frame(input int t, input logic [NB-1:0] w,
                              input logic [5:0] init, input int nbits);
        q_load.push_back('{c: t + 1, v: init});
        for (int k = 0; k < nbits; k++)
            q_bits.push_back('{c: t + 2 + k, v: {5'b0, w[k]}});
    endtask

    task automatic start_at(input int t, input logic [NB-1:0] w);
        run_to(t);
        start    = 1'b1;
        sig_word = w;
        run_to(t + 1);
        start    = 1'b0;
    endtask

    task automatic pulse(input int c, input bit is_abort, input bit is_done);
        run_to(c);
        abort   = is_abort;
        sc_done = is_done;
        run_to(c + 1);
        abort   = 1'b0;
        sc_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sig_word = '0; abort = 1'b0; sc_done = 1'b0;
        run_to(3);
        chk("rst_ready", {7'b0, ready}, 8'd1);
        chk("rst_busy", {7'b0, busy}, 8'd0);
        chk("rst_vld", {7'b0, sc_di_vld}, 8'd0);
        chk("rst_init", {2'b0, sc_di_init}, 8'd0);
        chk("rst_done_err", {6'b0, done, err_timeout}, 8'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Nominal: A5C3_0F96, seed word[31:26]=101001, sc_done 300 cycles
        // into WAIT (WAIT entered at 39). A stray sc_done in SEND and one
        // in IDLE must be ignored.
        push_frame(5, 32'hA5C3_0F96, 6'b101001, NB);
        q_evt.push_back('{c: 340, v: K_DONE});
        q_rdy.push_back('{c: 344, v: 6'd1});
        start_at(5, 32'hA5C3_0F96);
        pulse(10, 1'b0, 1'b1);
        pulse(339, 1'b0, 1'b1);
        pulse(346, 1'b0, 1'b1);

        // start together with abort in IDLE: blocked, nothing expected.
        run_to(348);
        start = 1'b1; abort = 1'b1; sig_word = 32'hFFFF_FFFF;
        run_to(349);
        start = 1'b0; abort = 1'b0;

        // Timeout: WAIT entered at 384, err_timeout at 784.
        push_frame(350, 32'h1234_5678, 6'b000100, NB);
        q_evt.push_back('{c: 784, v: K_TMO});
        q_rdy.push_back('{c: 788, v: 6'd1});
        start_at(350, 32'h1234_5678);

        // Race: sc_done on the 400th WAIT cycle (824+399) wins.
        push_frame(790, 32'hFFFF_0001, 6'b111111, NB);
        q_evt.push_back('{c: 1224, v: K_DONE});
        q_rdy.push_back('{c: 1228, v: 6'd1});
        start_at(790, 32'hFFFF_0001);
        pulse(1223, 1'b0, 1'b1);

        // Abort at SEND k=10 (cycle 1242): bits 0..10 only, GAP 1243..1246.
        // start and abort during GAP are ignored.
        push_frame(1230, 32'h0F0F_3C3C, 6'b000011, 11);
        q_rdy.push_back('{c: 1247, v: 6'd1});
        start_at(1230, 32'h0F0F_3C3C);
        pulse(1242, 1'b1, 1'b0);
        run_to(1243);
        start = 1'b1;
        run_to(1245);
        abort = 1'b1;
        run_to(1246);
        start = 1'b0; abort = 1'b0;

        // Abort in WAIT coinciding with sc_done: no done pulse.
        push_frame(1250, 32'hDEAD_BEEF, 6'b110111, NB);
        q_rdy.push_back('{c: 1299, v: 6'd1});
        start_at(1250, 32'hDEAD_BEEF);
        pulse(1294, 1'b1, 1'b1);

        // Reset at SEND k=20 (cycle 1322), then a complete new frame.
        push_frame(1300, 32'hCAFE_1234, 6'b110010, 21);
        q_rdy.push_back('{c: 1323, v: 6'd1});
        start_at(1300, 32'hCAFE_1234);
        run_to(1322);
        rst = 1'b1;
        run_to(1323);
        rst = 1'b0;
        chk("rrst_vld", {7'b0, sc_di_vld}, 8'd0);
        chk("rrst_di", {7'b0, sc_di}, 8'd0);
        chk("rrst_init", {2'b0, sc_di_init}, 8'd0);
        chk("rrst_busy", {7'b0, busy}, 8'd0);
        chk("rrst_done_err", {6'b0, done, err_timeout}, 8'd0);
        push_frame(1325, 32'h8000_0001, 6'b100000, NB);
        q_evt.push_back('{c: 1362, v: K_DONE});
        q_rdy.push_back('{c: 1366, v: 6'd1});
        start_at(1325, 32'h8000_0001);
        pulse(1361, 1'b0, 1'b1);

        // Back-to-back: start held high; first done at 1407, second LOAD at
        // 1412 = done + GAP_CYC + 1.
        push_frame(1370, 32'h1357_9BDF, 6'b000100, NB);
        q_evt.push_back('{c: 1407, v: K_DONE});
        q_rdy.push_back('{c: 1411, v: 6'd1});
        push_frame(1411, 32'h2468_ACE0, 6'b001001, NB);
        q_evt.push_back('{c: 1451, v: K_DONE});
        q_rdy.push_back('{c: 1455, v: 6'd1});
        run_to(1370);
        start = 1'b1; sig_word = 32'h1357_9BDF;
        run_to(1380);
        sig_word = 32'h2468_ACE0;
        pulse(1406, 1'b0, 1'b1);
        run_to(1412);
        start = 1'b0;
        pulse(1450, 1'b0, 1'b1);

        run_to(1470);
        mon_en = 1'b0;
        chk("left_bits", 8'(q_bits.size()), 8'd0);
        chk("left_load", 8'(q_load.size()), 8'd0);
        chk("left_evt", 8'(q_evt.size()), 8'd0);
        chk("left_rdy", 8'(q_rdy.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
